// File: rtl/cordic_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the shared CORDIC pipeline.
// slave: arbiter view. master: requesters plus CORDIC pipeline view.
interface cordic_arbiter_if;
    logic        a_req_valid;
    logic        a_req_ready;
    logic [31:0] a_req_radian;
    logic        b_req_valid;
    logic        b_req_ready;
    logic [31:0] b_req_radian;

    logic        a_rsp_valid;
    logic        a_rsp_ready;
    logic [15:0] a_rsp_sin;
    logic [15:0] a_rsp_cos;
    logic        b_rsp_valid;
    logic        b_rsp_ready;
    logic [15:0] b_rsp_sin;
    logic [15:0] b_rsp_cos;

    logic        cordic_valid_in;
    logic [31:0] cordic_radian;
    logic        cordic_valid_out;
    logic [15:0] cordic_sin;
    logic [15:0] cordic_cos;

    modport slave (
        input  a_req_valid, a_req_radian, b_req_valid, b_req_radian,
        output a_req_ready, b_req_ready,
        input  a_rsp_ready, b_rsp_ready,
        output a_rsp_valid, a_rsp_sin, a_rsp_cos, b_rsp_valid, b_rsp_sin, b_rsp_cos,
        output cordic_valid_in, cordic_radian,
        input  cordic_valid_out, cordic_sin, cordic_cos
    );

    modport master (
        output a_req_valid, a_req_radian, b_req_valid, b_req_radian,
        input  a_req_ready, b_req_ready,
        output a_rsp_ready, b_rsp_ready,
        input  a_rsp_valid, a_rsp_sin, a_rsp_cos, b_rsp_valid, b_rsp_sin, b_rsp_cos,
        input  cordic_valid_in, cordic_radian,
        output cordic_valid_out, cordic_sin, cordic_cos
    );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one fixed-latency CORDIC pipeline between two requesters.
// Results are routed back by a tag shift register that mirrors the pipeline; per-requester
// credits bound in-flight plus buffered results so the response FIFOs never overflow.
module cordic_arbiter #(
    parameter int unsigned LATENCY    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    cordic_arbiter_if.slave bus,
    output logic            err
);
    localparam int unsigned   PW          = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW          = PW + 1;
    localparam logic [CW-1:0] CREDIT_FULL = CW'(FIFO_DEPTH);

    // Index 0 is requester A, index 1 is requester B.
    logic [1:0]         req_valid, rsp_ready, elig, grant, push, pop, empty, full;
    logic [31:0]        req_radian [2];
    logic [31:0]        head [2];
    logic               accept, grant_id;
    logic               tag_out_valid, tag_out_owner, hit, proto_err, overflow;

    logic               last_grant_q;
    logic [LATENCY-1:0] tag_valid_q, tag_owner_q;
    logic [CW-1:0]      credit_q [2];
    logic [CW-1:0]      count_q [2];
    logic [PW-1:0]      wptr_q [2];
    logic [PW-1:0]      rptr_q [2];
    logic [31:0]        mem_q [2][FIFO_DEPTH];
    logic               err_q;

    // Grant selection, result routing and FIFO handshake decode
    always_comb begin
        req_valid     = {bus.b_req_valid, bus.a_req_valid};
        rsp_ready     = {bus.b_rsp_ready, bus.a_rsp_ready};
        req_radian[0] = bus.a_req_radian;
        req_radian[1] = bus.b_req_radian;
        tag_out_valid = tag_valid_q[LATENCY-1];
        tag_out_owner = tag_owner_q[LATENCY-1];
        hit           = bus.cordic_valid_out && tag_out_valid;
        proto_err     = bus.cordic_valid_out != tag_out_valid;
        elig          = '0;
        grant         = '0;
        push          = '0;
        pop           = '0;
        empty         = '0;
        full          = '0;
        overflow      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            elig[i]  = req_valid[i] && (credit_q[i] != '0);
            empty[i] = count_q[i] == '0;
            full[i]  = count_q[i] == CREDIT_FULL;
            pop[i]   = !empty[i] && rsp_ready[i];
            head[i]  = empty[i] ? '0 : mem_q[i][rptr_q[i]];
        end
        // Reset gates the grant so req_ready reads low while reset is held.
        if (reset) begin
            if (elig[0] && (!elig[1] || last_grant_q)) begin
                grant[0] = 1'b1;
            end else if (elig[1]) begin
                grant[1] = 1'b1;
            end
        end
        accept   = |grant;
        grant_id = grant[1];
        for (int i = 0; i < 2; i++) begin
            if (hit && (tag_out_owner == 1'(i))) begin
                // A pop in the same cycle frees the slot, so a full FIFO can still take it.
                if (full[i] && !pop[i]) begin
                    overflow = 1'b1;
                end else begin
                    push[i] = 1'b1;
                end
            end
        end
    end

    assign bus.a_req_ready     = grant[0];
    assign bus.b_req_ready     = grant[1];
    assign bus.cordic_valid_in = accept;
    assign bus.cordic_radian   = accept ? req_radian[grant_id] : '0;
    assign bus.a_rsp_valid     = !empty[0];
    assign bus.a_rsp_sin       = head[0][31:16];
    assign bus.a_rsp_cos       = head[0][15:0];
    assign bus.b_rsp_valid     = !empty[1];
    assign bus.b_rsp_sin       = head[1][31:16];
    assign bus.b_rsp_cos       = head[1][15:0];
    assign err                 = err_q;

    // Round-robin pointer, tag pipeline, credits, FIFO pointers and sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            tag_valid_q  <= '0;
            tag_owner_q  <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                credit_q[i] <= CREDIT_FULL;
                count_q[i]  <= '0;
                wptr_q[i]   <= '0;
                rptr_q[i]   <= '0;
            end
        end else begin
            if (accept) begin
                last_grant_q <= grant_id;
            end
            tag_valid_q[0] <= accept;
            tag_owner_q[0] <= grant_id;
            for (int s = 1; s < LATENCY; s++) begin
                tag_valid_q[s] <= tag_valid_q[s-1];
                tag_owner_q[s] <= tag_owner_q[s-1];
            end
            for (int i = 0; i < 2; i++) begin
                credit_q[i] <= credit_q[i] - CW'(grant[i]) + CW'(pop[i]);
                count_q[i]  <= count_q[i] + CW'(push[i]) - CW'(pop[i]);
                if (push[i]) begin
                    wptr_q[i] <= wptr_q[i] + PW'(1);
                end
                if (pop[i]) begin
                    rptr_q[i] <= rptr_q[i] + PW'(1);
                end
            end
            if (proto_err || overflow) begin
                err_q <= 1'b1;
            end
        end
    end

    // FIFO storage; reads are masked by occupancy so no reset is needed
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= {bus.cordic_sin, bus.cordic_cos};
            end
        end
    end
endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: stand-in CORDIC pipeline plus a queue-based reference model.
module tb_cordic_arbiter;
    localparam int unsigned LATENCY    = 16;
    localparam int unsigned FIFO_DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic err;
    logic inject = 1'b0;
    logic mon_en = 1'b0;

    cordic_arbiter_if bus ();

    cordic_arbiter #(
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in CORDIC: arbitrary but deterministic function of the angle.
    function automatic logic [15:0] f_sin(input logic [31:0] r);
        return r[15:0] ^ 16'h5a5a;
    endfunction
    function automatic logic [15:0] f_cos(input logic [31:0] r);
        return r[31:16] + {8'h00, r[7:0]};
    endfunction

    logic [LATENCY-1:0] pipe_v;
    logic [31:0]        pipe_r [LATENCY];

    // Fixed-latency pipeline sharing the arbiter reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_v <= '0;
            for (int s = 0; s < LATENCY; s++) pipe_r[s] <= '0;
        end else begin
            pipe_v    <= {pipe_v[LATENCY-2:0], bus.cordic_valid_in};
            pipe_r[0] <= bus.cordic_radian;
            for (int s = 1; s < LATENCY; s++) pipe_r[s] <= pipe_r[s-1];
        end
    end

    assign bus.cordic_valid_out = pipe_v[LATENCY-1] | inject;
    assign bus.cordic_sin       = f_sin(pipe_r[LATENCY-1]);
    assign bus.cordic_cos       = f_cos(pipe_r[LATENCY-1]);

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: outstanding results in acceptance order, each with the first
    // cycle it may be visible at its requester.
    typedef struct packed {
        logic        owner;
        logic [31:0] data;
        int          avail;
    } entry_t;

    entry_t exp_q[$];
    int     cred [2];
    int     last_m;
    bit     err_m;
    int     a_hs, b_hs, a_acc_cyc, a_rsp_first, b_rsp_seen;

    task automatic model_reset();
        exp_q.delete();
        cred[0] = FIFO_DEPTH;
        cred[1] = FIFO_DEPTH;
        last_m  = 1;
        err_m   = 1'b0;
    endtask

    task automatic monitor_cycle();
        logic        ea, eb, ga, gb, ev, rv, rr;
        logic [31:0] erad, rdata;
        int          h;
        entry_t      e;
        ea = bus.a_req_valid && (cred[0] > 0);
        eb = bus.b_req_valid && (cred[1] > 0);
        ga = ea && (!eb || last_m == 1);
        gb = eb && !ga;
        erad = ga ? bus.a_req_radian : (gb ? bus.b_req_radian : 32'h0);
        check_eq("a_req_ready", 32'(bus.a_req_ready), 32'(ga));
        check_eq("b_req_ready", 32'(bus.b_req_ready), 32'(gb));
        check_eq("cordic_valid_in", 32'(bus.cordic_valid_in), 32'(ga || gb));
        check_eq("cordic_radian", bus.cordic_radian, erad);
        if (bus.a_req_valid && bus.a_req_ready) begin
            a_hs++;
            a_acc_cyc = cyc;
        end
        if (bus.b_req_valid && bus.b_req_ready) b_hs++;
        if (bus.a_rsp_valid && a_rsp_first < 0) a_rsp_first = cyc;
        if (bus.b_rsp_valid) b_rsp_seen++;
        for (int i = 0; i < 2; i++) begin
            h = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (exp_q[k].owner == 1'(i)) begin
                    h = k;
                    break;
                end
            end
            ev    = (h >= 0) && (exp_q[h].avail <= cyc);
            rv    = (i == 0) ? bus.a_rsp_valid : bus.b_rsp_valid;
            rr    = (i == 0) ? bus.a_rsp_ready : bus.b_rsp_ready;
            rdata = (i == 0) ? {bus.a_rsp_sin, bus.a_rsp_cos} : {bus.b_rsp_sin, bus.b_rsp_cos};
            check_eq($sformatf("%s_rsp_valid", (i == 0) ? "a" : "b"), 32'(rv), 32'(ev));
            if (ev) begin
                check_eq($sformatf("%s_rsp_data", (i == 0) ? "a" : "b"), rdata, exp_q[h].data);
                if (rr) begin
                    exp_q.delete(h);
                    cred[i]++;
                end
            end
        end
        check_eq("err", 32'(err), 32'(err_m));
        if (inject) err_m = 1'b1;
        if (ga || gb) begin
            e.owner = gb;
            e.data  = {f_sin(erad), f_cos(erad)};
            e.avail = cyc + LATENCY + 1;
            exp_q.push_back(e);
            cred[gb ? 1 : 0]--;
            last_m = gb ? 1 : 0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) monitor_cycle();
        end
    end

    task automatic drive_idle();
        bus.a_req_valid  = 1'b0;
        bus.b_req_valid  = 1'b0;
        bus.a_req_radian = '0;
        bus.b_req_radian = '0;
        bus.a_rsp_ready  = 1'b1;
        bus.b_rsp_ready  = 1'b1;
    endtask

    task automatic drive_random(input int pa, input int pb, input int pra, input int prb);
        bus.a_req_valid  = $urandom_range(0, 99) < pa;
        bus.b_req_valid  = $urandom_range(0, 99) < pb;
        bus.a_req_radian = $urandom();
        bus.b_req_radian = $urandom();
        bus.a_rsp_ready  = $urandom_range(0, 99) < pra;
        bus.b_rsp_ready  = $urandom_range(0, 99) < prb;
    endtask

    task automatic run_random(input int n, input int pa, input int pb, input int pra,
                              input int prb);
        repeat (n) begin
            @(posedge clk);
            #1 drive_random(pa, pb, pra, prb);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_a_req_ready", 32'(bus.a_req_ready), 32'h0);
        check_eq("rst_b_req_ready", 32'(bus.b_req_ready), 32'h0);
        check_eq("rst_cordic_valid_in", 32'(bus.cordic_valid_in), 32'h0);
        check_eq("rst_cordic_radian", bus.cordic_radian, 32'h0);
        check_eq("rst_a_rsp_valid", 32'(bus.a_rsp_valid), 32'h0);
        check_eq("rst_a_rsp_data", {bus.a_rsp_sin, bus.a_rsp_cos}, 32'h0);
        check_eq("rst_b_rsp_valid", 32'(bus.b_rsp_valid), 32'h0);
        check_eq("rst_b_rsp_data", {bus.b_rsp_sin, bus.b_rsp_cos}, 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
    endtask

    // Asynchronous assertion mid-cycle, release just after a clock edge.
    task automatic apply_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        mon_en = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        mon_en = 1'b1;
    endtask

    int a0, b0;
    int pv [4] = '{0, 30, 70, 100};

    initial begin
        drive_idle();
        bus.a_req_valid = 1'b1;
        bus.b_req_valid = 1'b1;
        a_hs = 0; b_hs = 0; a_acc_cyc = 0; a_rsp_first = -1; b_rsp_seen = 0;
        model_reset();
        apply_reset();

        // Single A request: issue same cycle, response 17 cycles later, B untouched
        drive_idle();
        @(posedge clk);
        #1 bus.a_req_valid = 1'b1;
        bus.a_req_radian = 32'h0000_1921;
        a_rsp_first = -1;
        b_rsp_seen  = 0;
        @(posedge clk);
        #1 drive_idle();
        repeat (25) @(posedge clk);
        @(negedge clk);
        #1 check_eq("a_latency", 32'(a_rsp_first - a_acc_cyc), 32'(LATENCY + 1));
        check_eq("b_rsp_quiet", 32'(b_rsp_seen), 32'h0);

        // Both requesting every cycle: alternating grants, one issue per cycle
        a0 = a_hs;
        b0 = b_hs;
        repeat (8) begin
            @(posedge clk);
            #1 drive_random(100, 100, 100, 100);
        end
        @(negedge clk);
        #1 check_eq("alt_total", 32'((a_hs - a0) + (b_hs - b0)), 32'd8);
        check_eq("alt_a", 32'(a_hs - a0), 32'd4);
        run_random(40, 100, 100, 100, 100);

        // A backpressured: credits stop A after FIFO_DEPTH, B keeps flowing
        run_random(30, 0, 0, 100, 100);
        a0 = a_hs;
        b0 = b_hs;
        run_random(40, 100, 60, 0, 100);
        @(negedge clk);
        #1 check_eq("a_credit_stop", 32'(a_hs - a0), 32'(FIFO_DEPTH));
        check_eq("b_served", 32'(b_hs - b0 > 0), 32'h1);
        run_random(40, 100, 60, 100, 100);

        // Randomized traffic across a spread of load and backpressure mixes
        for (int seg = 0; seg < 12; seg++) begin
            run_random(250, pv[$urandom_range(0, 3)], pv[$urandom_range(0, 3)],
                       pv[$urandom_range(0, 3)], pv[$urandom_range(0, 3)]);
        end

        // Spurious pipeline valid with nothing in flight
        run_random(40, 0, 0, 100, 100);
        @(posedge clk);
        #1 inject = 1'b1;
        @(posedge clk);
        #1 inject = 1'b0;
        run_random(20, 0, 0, 100, 100);
        @(negedge clk);
        #1 check_eq("err_sticky", 32'(err), 32'h1);
        run_random(30, 60, 60, 70, 70);
        apply_reset();

        // Reset with requests in flight: nothing returns, credits back to full
        repeat (5) begin
            @(posedge clk);
            #1 drive_random(100, 100, 100, 100);
        end
        apply_reset();
        a0 = a_hs;
        b_rsp_seen = 0;
        a_rsp_first = -1;
        run_random(30, 100, 0, 0, 100);
        @(negedge clk);
        #1 check_eq("post_rst_credit", 32'(a_hs - a0), 32'(FIFO_DEPTH));
        check_eq("post_rst_no_b_rsp", 32'(b_rsp_seen), 32'h0);
        run_random(60, 50, 50, 80, 80);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter LATENCY, default 16, fixed cycles from cordic_valid_in to matching cordic_valid_out of the shared CORDIC pipeline.
REQ-002 Parameter FIFO_DEPTH, default 4, entries per requester response FIFO (power of two, >=2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 a_req_valid, a_req_ready  input/output  1 each  requester A request handshake.
REQ-006 a_req_radian  input  32  requester A angle.
REQ-007 b_req_valid, b_req_ready, b_req_radian  as REQ-005/006 for requester B.
REQ-008 a_rsp_valid  output 1; a_rsp_ready  input 1; a_rsp_sin, a_rsp_cos  output 16 each  requester A response.
REQ-009 b_rsp_valid, b_rsp_ready, b_rsp_sin, b_rsp_cos  as REQ-008 for requester B.
REQ-010 cordic_valid_in  output 1; cordic_radian  output 32  issue to CORDIC pipeline.
REQ-011 cordic_valid_out  input 1; cordic_sin, cordic_cos  input 16 each  CORDIC results.
REQ-012 err  output 1  sticky protocol-error flag.

Function
REQ-013 Request accepted when req_valid && req_ready same cycle; at most one acceptance per cycle across A and B.
REQ-014 Requester eligible when req_valid=1 and its credit counter >0.
REQ-015 Only A eligible -> grant A; only B -> grant B; both -> grant requester not granted last (round-robin); none -> no grant.
REQ-016 req_ready combinational: high only for granted requester; never asserted while credit=0.
REQ-017 On acceptance, same cycle: cordic_valid_in=1, cordic_radian=accepted radian; otherwise cordic_valid_in=0, cordic_radian=0.
REQ-018 last_grant updates only on acceptance.
REQ-019 Tag shift register, LATENCY stages of {valid, owner}, advances every cycle; stage 0 loads {acceptance, granted id}.
REQ-020 When cordic_valid_out=1 and tag output valid=1, {cordic_sin, cordic_cos} pushed into owner's FIFO that cycle.
REQ-021 cordic_valid_out differing from tag output valid -> err set, data dropped; err clears only on reset.
REQ-022 Credit counter per requester, width clog2(FIFO_DEPTH)+1, = FIFO_DEPTH minus (in-flight + FIFO occupancy); decrement on acceptance, increment on rsp pop; both same cycle -> unchanged.
REQ-023 Credit guarantees no FIFO overflow; push into full FIFO is impossible by construction and also sets err.
REQ-024 rsp_valid = FIFO non-empty; rsp_sin/rsp_cos = head entry; pop when rsp_valid && rsp_ready.
REQ-025 FIFO push and pop same cycle: both occur, occupancy unchanged, including when full or with one entry.
REQ-026 Responses per requester returned in acceptance order; acceptance-to-rsp_valid latency LATENCY+1 cycles when FIFO empty.
REQ-027 No combinational path from cordic_* inputs to rsp_* outputs.
REQ-028 Read/write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-029 reset=0 asynchronously: req_ready=0, cordic_valid_in=0, cordic_radian=0, rsp_valid=0, rsp_sin/cos=0 (A and B), err=0.
REQ-030 Reset: tag register cleared, FIFOs emptied, credits=FIFO_DEPTH, last_grant=B (A wins first tie).
REQ-031 Reset mid-operation discards all in-flight and buffered results; CORDIC pipeline shares same reset.

Verification
REQ-032 A only, radian=0x0000_1921, rsp_ready=1 -> cordic_valid_in same cycle; a_rsp_valid exactly 17 cycles later with pipeline data; b_rsp_valid stays 0.
REQ-033 A and B valid every cycle, both rsp_ready=1 -> grants alternate A,B,A,B from first cycle after reset; one issue per cycle.
REQ-034 A valid every cycle, a_rsp_ready=0 -> exactly 4 acceptances then a_req_ready=0; B still served; A resumes one cycle after first pop.
REQ-035 A FIFO full, a_rsp_ready=1 while new result arrives -> push+pop same cycle, occupancy stays 4, no err.
REQ-036 Inject cordic_valid_out=1 with no in-flight tag -> err=1 next cycle, no rsp_valid; err held until reset.
REQ-037 Assert reset with 5 requests in flight -> all outputs zero immediately, no responses after release, credits=4 each.
